// File: rtl/sample_delay_ram.sv
// Circular delay line in a synchronous-read RAM; each accepted sample emits TAPS taps, newest first.
// Optional macro DLY_CLEAR_EN: sweep zeros through the RAM after reset before accepting samples.
module sample_delay_ram #(
  parameter int D_WIDTH = 24,
  parameter int A_WIDTH = 6,
  parameter int DEPTH   = 1 << A_WIDTH,
  parameter int TAPS    = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [D_WIDTH-1:0]                         in_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [D_WIDTH-1:0]                         out_data,
  output logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] out_tap,
  output logic                                       out_last
);
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TW-1:0]      LAST_TAP = TW'(TAPS - 1);
  localparam logic [A_WIDTH-1:0] TOP_ADDR = A_WIDTH'(DEPTH - 1);

`ifdef DLY_CLEAR_EN
  typedef enum logic [1:0] {CLEAR, IDLE, READ} state_t;
  localparam state_t RST_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, READ} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t             r_state, w_state_nxt;
  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic [A_WIDTH-1:0] r_wr_ptr, r_rd_addr, w_waddr;
  logic [D_WIDTH-1:0] r_s1_data, r_out_data, w_wdata;
  logic [TW-1:0]      r_iss_k, r_s1_tap, r_out_tap;
  logic               r_iss_act, r_s1_vld, r_s1_last, r_out_valid, r_out_last;
  logic               w_accept, w_s2_en, w_issue, w_last_hs, w_we;
`ifdef DLY_CLEAR_EN
  logic [A_WIDTH-1:0] r_clr;
`endif

  assign in_ready  = (r_state == IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  // Stage 1 is the RAM read register, stage 2 the output/hold register.
  assign w_s2_en   = !r_out_valid || out_ready;
  assign w_issue   = r_iss_act && (!r_s1_vld || w_s2_en);
  assign w_last_hs = r_out_valid && out_ready && r_out_last;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tap   = r_out_tap;
  assign out_last  = r_out_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RST_STATE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef DLY_CLEAR_EN
      CLEAR:   if (r_clr == TOP_ADDR) w_state_nxt = IDLE;
`endif
      IDLE:    if (w_accept) w_state_nxt = READ;
      READ:    if (w_last_hs) w_state_nxt = IDLE;
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_comb begin
    w_we    = w_accept;
    w_waddr = r_wr_ptr;
    w_wdata = in_data;
`ifdef DLY_CLEAR_EN
    if (r_state == CLEAR && !rst) begin
      w_we    = 1'b1;
      w_waddr = r_clr;
      w_wdata = '0;
    end
`endif
  end

`ifdef DLY_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst)                   r_clr <= '0;
    else if (r_state == CLEAR) r_clr <= r_clr + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (w_we)    r_mem[w_waddr] <= w_wdata;
    if (w_issue) r_s1_data      <= r_mem[r_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_addr   <= '0;
      r_iss_k     <= '0;
      r_iss_act   <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_tap    <= '0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tap   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr  <= (r_wr_ptr == TOP_ADDR) ? '0 : r_wr_ptr + 1'b1;
        r_rd_addr <= r_wr_ptr;
        r_iss_k   <= '0;
        r_iss_act <= 1'b1;
      end else if (w_issue) begin
        r_rd_addr <= (r_rd_addr == '0) ? TOP_ADDR : r_rd_addr - 1'b1;
        r_iss_k   <= r_iss_k + 1'b1;
        if (r_iss_k == LAST_TAP) r_iss_act <= 1'b0;
      end

      if (w_issue) begin
        r_s1_vld  <= 1'b1;
        r_s1_tap  <= r_iss_k;
        r_s1_last <= (r_iss_k == LAST_TAP);
      end else if (r_s1_vld && w_s2_en) begin
        r_s1_vld  <= 1'b0;
      end

      if (w_s2_en) begin
        r_out_valid <= r_s1_vld;
        r_out_last  <= r_s1_vld && r_s1_last;
        if (r_s1_vld) begin
          r_out_data <= r_s1_data;
          r_out_tap  <= r_s1_tap;
        end
      end
    end
  end
endmodule

// File: tb/tb_sample_delay_ram.sv
// Bench for sample_delay_ram (DEPTH=8, TAPS=4): directed vector table, hand-written
// backpressure/reset sequences and random pushes against an array model of the delay line.
module tb_sample_delay_ram;
  localparam int DW = 24, AW = 3, DEPTH = 8, TAPS = 4;
`ifdef DLY_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b1, out_last;
  logic [DW-1:0] out_data;
  logic [1:0]    out_tap;

  sample_delay_ram #(.D_WIDTH(DW), .A_WIDTH(AW), .DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tap(out_tap), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]                din;
    logic [TAPS-1:0][DW-1:0]      exp;
    logic [TAPS-1:0]              msk;
    int                           stall_k;
    int                           stall_n;
    bit                           hold_v;
  } vec_t;

  int            n_cmp = 0, n_bad = 0;
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_known [DEPTH];
  int            mdl_wr = 0;
  vec_t          tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic release_check();
    rst = 1'b0;
    #1;
    chk("rel_ready_c1", {31'd0, in_ready}, CLR ? 32'd0 : 32'd1);
    if (CLR) begin
      for (int c = 2; c <= DEPTH + 1; c++) begin
        @(negedge clk);
        chk($sformatf("rel_ready_c%0d", c), {31'd0, in_ready}, (c == DEPTH + 1) ? 32'd1 : 32'd0);
      end
    end
    mdl_wr = 0;
    if (CLR) for (int a = 0; a < DEPTH; a++) begin mdl_mem[a] = '0; mdl_known[a] = 1'b1; end
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_last",  {31'd0, out_last}, 0);
    chk("rst_tap",   {30'd0, out_tap}, 0);
    chk("rst_data",  {8'd0, out_data}, 0);
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_wrptr", {29'd0, dut.r_wr_ptr}, 0);
    release_check();
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    ok = in_ready;
    if (!ok) fail_now("in_ready_wait");
  endtask

  // Push one sample; drain its taps with an optional stall of stall_n cycles on tap stall_k.
  task automatic push(input logic [DW-1:0] d, input logic [TAPS-1:0][DW-1:0] exp_in,
                      input logic [TAPS-1:0] msk_in, input bit use_mdl,
                      input int stall_k, input int stall_n, input bit hold_v);
    logic [TAPS-1:0][DW-1:0] exp;
    logic [TAPS-1:0]         msk;
    int base, k, st, cyc, a;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(negedge clk);
    base = mdl_wr;
    mdl_mem[base] = d; mdl_known[base] = 1'b1;
    mdl_wr = (mdl_wr + 1) % DEPTH;
    exp = exp_in; msk = msk_in;
    if (use_mdl) begin
      for (int t = 0; t < TAPS; t++) begin
        a = (base - t + DEPTH) % DEPTH;
        exp[t] = mdl_mem[a];
        msk[t] = !mdl_known[a];
      end
    end
    in_valid = hold_v; in_data = ~d;
    chk("lat_c0_valid", {31'd0, out_valid}, 0);
    chk("busy_ready",   {31'd0, in_ready}, 0);
    k = 0; st = 0; cyc = 0;
    while (k < TAPS && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("lat_c1_valid", {31'd0, out_valid}, 0);
      if (cyc == 2) chk("lat_c2_valid", {31'd0, out_valid}, 1);
      if (out_valid) begin
        chk($sformatf("tap%0d_idx", k),  {30'd0, out_tap}, k);
        chk($sformatf("tap%0d_last", k), {31'd0, out_last}, (k == TAPS - 1) ? 1 : 0);
        if (!msk[k]) chk($sformatf("tap%0d_data", k), {8'd0, out_data}, {8'd0, exp[k]});
        if (k == stall_k && st < stall_n) begin
          out_ready = 1'b0;
          st++;
        end else begin
          out_ready = 1'b1;
          if (k == TAPS - 1) in_valid = 1'b0;
          k++;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    if (k < TAPS) begin
      fail_now("tap_drain");
      in_valid = 1'b0;
    end
    @(negedge clk);
    chk("end_valid", {31'd0, out_valid}, 0);
    chk("end_ready", {31'd0, in_ready}, 1);
    chk("end_wrptr", {29'd0, dut.r_wr_ptr}, mdl_wr);
  endtask

  task automatic abort_test(input logic [DW-1:0] d);
    int n = 0;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!(out_valid && out_tap == 2'd2) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail_now("abort_tap2_wait");
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", {31'd0, out_valid}, 0);
    chk("abort_last",  {31'd0, out_last}, 0);
    chk("abort_tap",   {30'd0, out_tap}, 0);
    chk("abort_data",  {8'd0, out_data}, 0);
    chk("abort_ready", {31'd0, in_ready}, 0);
    chk("abort_wrptr", {29'd0, dut.r_wr_ptr}, 0);
    @(negedge clk);
    chk("abort_quiet", {31'd0, out_valid}, 0);
    // the sample did land in RAM before the abort
    mdl_mem[mdl_wr] = d; mdl_known[mdl_wr] = 1'b1;
    release_check();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [TAPS-1:0][DW-1:0] e;
    logic [TAPS-1:0]         m;
    for (int a = 0; a < DEPTH; a++) begin mdl_mem[a] = '0; mdl_known[a] = 1'b0; end
    // Sample i+1 pushed i-th after reset: tap k is (i+1-k), older than history is 0/masked.
    for (int i = 0; i < 10; i++) begin
      tbl[i].din = DW'(i + 1);
      for (int k = 0; k < TAPS; k++) begin
        tbl[i].exp[k] = (i + 1 - k >= 1) ? DW'(i + 1 - k) : '0;
        tbl[i].msk[k] = (i + 1 - k < 1) && !CLR;
      end
      tbl[i].stall_k = (i == 2) ? 1 : -1;
      tbl[i].stall_n = (i == 2) ? 3 : 0;
      tbl[i].hold_v  = (i == 2);
    end

    apply_reset();
    e = '0; e[0] = 24'h000011;
    m = CLR ? 4'b0000 : 4'b1110;
    push(24'h000011, e, m, 1'b0, -1, 0, 1'b0);

    apply_reset();
    for (int i = 0; i < 10; i++)
      push(tbl[i].din, tbl[i].exp, tbl[i].msk, 1'b0, tbl[i].stall_k, tbl[i].stall_n, tbl[i].hold_v);
    chk("wrap_wrptr", {29'd0, dut.r_wr_ptr}, 2);

    for (int r = 0; r < 24; r++) begin
      e = '0; m = '0;
      push(DW'($urandom), e, m, 1'b1,
           ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, TAPS - 1)),
           int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
    end

    abort_test(24'h00ABCD);
    e = '0; m = '0;
    push(24'h000007, e, m, 1'b1, 2, 2, 1'b1);
    for (int r = 0; r < 6; r++) begin
      e = '0; m = '0;
      push(DW'($urandom), e, m, 1'b1, int'($urandom_range(0, TAPS - 1)), 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
